// File: rtl/seg_display_driver.sv
// seg_display_driver
//   Display stage for the card game. Captures a 14-bit binary value, converts it
//   to four BCD digits with a sequential double-dabble, and time-multiplexes the
//   digits onto a 4-digit common-anode seven-segment display. The display has
//   leading-zero blanking, per-digit decimal points and whole-display blink.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active high
//   scan_tick  one-cycle strobe: advances the digit scan and the blink counter
//   load       one-cycle strobe: captures value and (re)starts a conversion
//   value      unsigned binary value; anything above 9999 shows as 9999
//   dp         decimal point enables, bit 0 = rightmost digit
//   blink_en   level: blink the whole display while high
//   busy       high while a conversion is in flight
//   done       one-cycle pulse when new digits are committed to the display
//   seg        cathodes, active low: seg[6:0] = g..a, seg[7] = dp
//   an         anodes, active low, one-hot-low, an[0] = rightmost digit

module seg_display_driver #(
    parameter int BLINK_TICKS = 250,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_tick,
    input  logic        load,
    input  logic [13:0] value,
    input  logic [3:0]  dp,
    input  logic        blink_en,
    output logic        busy,
    output logic        done,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    localparam logic [13:0] MAX_BCD = 14'd9999;
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_TICKS - 1);

    state_t      state_q, state_d;
    logic [13:0] bin_q, bin_d;       // bits still to be shifted in, MSB first
    logic [15:0] bcd_q, bcd_d;       // conversion accumulator
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] disp_q, disp_d;     // committed digits shown on the display
    logic [1:0]  idx_q, idx_d;       // next digit to scan out
    logic [1:0]  pos_q, pos_d;       // digit currently driven on the anodes
    logic        shown_q, shown_d;   // anodes stay dark until the first scan
    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        blink_off_q, blink_off_d;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;

    logic [15:0] bcd_adj;
    logic [3:0]  digit;
    logic        blank;

    // Add 3 to a BCD nibble of 5 or more so the following shift carries correctly.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign bcd_adj = {add3(bcd_q[15:12]), add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

    // Conversion FSM and datapath.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        disp_d    = disp_q;

        case (state_q)
            S_SHIFT: begin
                bcd_d = {bcd_adj[14:0], bin_q[13]};
                bin_d = {bin_q[12:0], 1'b0};
                if (bit_cnt_q == 4'd13) begin
                    state_d = S_COMMIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            S_COMMIT: begin
                disp_d  = bcd_q;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        // A new load always wins: it discards any conversion in flight. A commit
        // in this same cycle still lands because disp_d was set above.
        if (load) begin
            state_d   = S_SHIFT;
            bin_d     = (value > MAX_BCD) ? MAX_BCD : value;
            bcd_d     = '0;
            bit_cnt_d = '0;
        end
    end

    // Scan, blanking and blink. The scan reads disp_d so a tick landing on the
    // commit cycle already shows the new digits.
    always_comb begin
        idx_d       = idx_q;
        pos_d       = pos_q;
        shown_d     = shown_q;
        seg_d       = seg_q;
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;

        digit = disp_d[{idx_q, 2'b00} +: 4];
        case (idx_q)
            2'd1:    blank = LZ_BLANK && (disp_d[15:4] == 12'd0);
            2'd2:    blank = LZ_BLANK && (disp_d[15:8] == 8'd0);
            2'd3:    blank = LZ_BLANK && (disp_d[15:12] == 4'd0);
            default: blank = 1'b0;   // rightmost digit is never blanked
        endcase

        if (scan_tick) begin
            pos_d   = idx_q;
            idx_d   = idx_q + 2'd1;
            shown_d = 1'b1;
            seg_d   = {~dp[idx_q], blank ? 7'h7F : encode(digit)};
        end

        if (!blink_en) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (scan_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end

        // Anodes are refreshed every cycle so blink_en falling takes effect at once.
        an_d = (!shown_d || blink_off_d) ? 4'hF : ~(4'b0001 << pos_d);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            bit_cnt_q   <= '0;
            disp_q      <= '0;
            idx_q       <= '0;
            pos_q       <= '0;
            shown_q     <= 1'b0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
            seg_q       <= 8'hFF;
            an_q        <= 4'hF;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            bit_cnt_q   <= bit_cnt_d;
            disp_q      <= disp_d;
            idx_q       <= idx_d;
            pos_q       <= pos_d;
            shown_q     <= shown_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_COMMIT);
    assign seg  = seg_q;
    assign an   = an_q;

endmodule
